programador_timer: RTL and testbench

- Upstream stage of control_alarma. Turns user push-button levels into a BCD timer setpoint: hours, minutes and seconds.
- On save, issues a three-step write burst on en_sav_swr/dataWr (0x43 hour, 0x42 min, 0x41 seg), which control_alarma latches.
- Also exports the live edit values and the cursor position to the VGA overlay.

---
 rtl/programador_timer_pkg.sv | 19 +
 rtl/programador_timer_field.sv | 27 ++
 rtl/programador_timer.sv | 115 +++++++++++
 tb/tb_programador_timer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/programador_timer_pkg.sv
// programador_timer_pkg: write tags, FSM encoding, cursor codes and BCD limits for the timer programmer
package programador_timer_pkg;
  localparam logic [7:0] TAG_HOUR = 8'h43;
  localparam logic [7:0] TAG_MIN = 8'h42;
  localparam logic [7:0] TAG_SEG = 8'h41;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;
  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [1:0] SEL_HOUR = 2'd0;
  localparam logic [1:0] SEL_MIN = 2'd1;
  localparam logic [1:0] SEL_SEG = 2'd2;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT,
    ST_WR_H,
    ST_WR_M,
    ST_WR_S,
    ST_FIN
  } state_t;
endpackage

// File: rtl/programador_timer_field.sv
// bcd_field_counter: two-digit BCD up/down counter wrapping between 00 and MAX_BCD
module bcd_field_counter
  import programador_timer_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_MAX_MS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [7:0] value
);
  logic [7:0] r_val, w_up, w_dn;
  always_comb begin
    w_up = (r_val == MAX_BCD) ? 8'h00 :
           (r_val[3:0] == 4'd9) ? {r_val[7:4] + 4'd1, 4'd0} : r_val + 8'd1;
    w_dn = (r_val == 8'h00) ? MAX_BCD :
           (r_val[3:0] == 4'd0) ? {r_val[7:4] - 4'd1, 4'd9} : r_val - 8'd1;
  end
  always_ff @(posedge clk) begin
    if (reset || clr) r_val <= 8'h00;
    else if (inc && !dec) r_val <= w_up;
    else if (dec && !inc) r_val <= w_dn;
  end
  assign value = r_val;
endmodule

// File: rtl/programador_timer.sv
// programador_timer: button-driven BCD setpoint editor that commits hour/min/seg as a tagged write burst
module programador_timer
  import programador_timer_pkg::*;
#(
  parameter logic [7:0] ADDR_HOUR = TAG_HOUR,
  parameter logic [7:0] ADDR_MIN = TAG_MIN,
  parameter logic [7:0] ADDR_SEG = TAG_SEG,
  parameter int HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_save,
  output logic [7:0] en_sav_swr,
  output logic [7:0] dataWr,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] seg_bcd,
  output logic [1:0] field_sel,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(HOLD_CYC + 1);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_sel;
  logic [4:0] r_prev;
  logic [7:0] r_tag, r_data;
  logic r_busy, r_done;
  logic [4:0] w_btn, w_edge;
  logic [2:0] w_hot, w_inc, w_dec;
  logic w_edit, w_save, w_lr, w_ud, w_wr, w_last;
  // bit order: save, left, right, up, down
  assign w_btn = {btn_save, btn_left, btn_right, btn_up, btn_down};
  assign w_edge = w_btn & ~r_prev;
  assign w_edit = (r_state == ST_EDIT) && en;
  assign w_save = w_edit && w_edge[4];
  assign w_lr = w_edit && !w_edge[4] && (w_edge[3] ^ w_edge[2]);
  assign w_ud = w_edit && !w_edge[4] && !(w_edge[3] | w_edge[2]) && (w_edge[1] ^ w_edge[0]);
  assign w_hot = {r_sel == SEL_SEG, r_sel == SEL_MIN, r_sel == SEL_HOUR};
  assign w_inc = {3{w_ud & w_edge[1]}} & w_hot;
  assign w_dec = {3{w_ud & w_edge[0]}} & w_hot;
  assign w_wr = r_state inside {ST_WR_H, ST_WR_M, ST_WR_S};
  assign w_last = r_cnt == CW'(HOLD_CYC - 1);
  bcd_field_counter #(.MAX_BCD(BCD_MAX_HOUR)) u_hour (
    .clk(clk), .reset(reset), .inc(w_inc[0]), .dec(w_dec[0]), .clr(1'b0), .value(hour_bcd)
  );
  bcd_field_counter #(.MAX_BCD(BCD_MAX_MS)) u_min (
    .clk(clk), .reset(reset), .inc(w_inc[1]), .dec(w_dec[1]), .clr(1'b0), .value(min_bcd)
  );
  bcd_field_counter #(.MAX_BCD(BCD_MAX_MS)) u_seg (
    .clk(clk), .reset(reset), .inc(w_inc[2]), .dec(w_dec[2]), .clr(1'b0), .value(seg_bcd)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_sel <= SEL_HOUR;
      r_prev <= '0;
      r_tag <= 8'h00;
      r_data <= 8'h00;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_prev <= w_btn;
      r_done <= 1'b0;
      r_cnt <= (w_wr && !w_last) ? r_cnt + 1'b1 : '0;
      case (r_state)
        ST_IDLE: if (en) r_state <= ST_EDIT;
        ST_EDIT:
          if (!en) r_state <= ST_IDLE;
          else if (w_save) begin
            r_state <= ST_WR_H;
            r_tag <= ADDR_HOUR;
            r_data <= hour_bcd;
            r_busy <= 1'b1;
          end else if (w_lr)
            r_sel <= w_edge[2] ? (r_sel == SEL_SEG ? SEL_HOUR : r_sel + 2'd1)
                               : (r_sel == SEL_HOUR ? SEL_SEG : r_sel - 2'd1);
        ST_WR_H:
          if (w_last) begin
            r_state <= ST_WR_M;
            r_tag <= ADDR_MIN;
            r_data <= min_bcd;
          end
        ST_WR_M:
          if (w_last) begin
            r_state <= ST_WR_S;
            r_tag <= ADDR_SEG;
            r_data <= seg_bcd;
          end
        ST_WR_S:
          if (w_last) begin
            r_state <= ST_FIN;
            r_tag <= 8'h00;
            r_done <= 1'b1;
          end
        ST_FIN: begin
          r_busy <= 1'b0;
          r_state <= en ? ST_EDIT : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign en_sav_swr = r_tag;
  assign dataWr = r_data;
  assign field_sel = r_sel;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_programador_timer.sv
// tb_programador_timer: directed checks of editing, BCD wrap, cursor, write burst and reset abort
module tb_programador_timer;
  import programador_timer_pkg::*;
  localparam logic [4:0] B_SAVE = 5'b10000, B_L = 5'b01000, B_R = 5'b00100, B_U = 5'b00010, B_D = 5'b00001;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_save = 1'b0;
  logic [7:0] en_sav_swr, dataWr, hour_bcd, min_bcd, seg_bcd;
  logic [1:0] field_sel;
  logic busy, done;
  int errors = 0, checks = 0;
  programador_timer dut (
    .clk(clk), .reset(reset), .en(en), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_save(btn_save),
    .en_sav_swr(en_sav_swr), .dataWr(dataWr), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
    .seg_bcd(seg_bcd), .field_sel(field_sel), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [4:0] m);
    {btn_save, btn_left, btn_right, btn_up, btn_down} = m;
    tick();
    {btn_save, btn_left, btn_right, btn_up, btn_down} = 5'b0;
    tick();
  endtask
  task automatic burst(input bit mess);
    int nb, nd;
    logic [7:0] et, ed;
    nb = 0;
    nd = 0;
    btn_save = 1'b1;
    tick();
    btn_save = 1'b0;
    for (int k = 0; k < 16; k++) begin
      et = k < 4 ? 8'h43 : k < 8 ? 8'h42 : k < 12 ? 8'h41 : 8'h00;
      ed = k < 4 ? 8'h12 : k < 8 ? 8'h34 : 8'h56;
      chk($sformatf("tag_k%0d", k), en_sav_swr, et);
      if (k < 14) chk($sformatf("data_k%0d", k), dataWr, ed);
      nb += int'(busy);
      nd += int'(done);
      if (k == 12) chk("done_fin", {7'b0, done}, 8'd1);
      if (mess) begin
        btn_up = (k < 12) ? k[0] : 1'b0;
        if (k == 2) en = 1'b0;
      end
      tick();
    end
    chk("busy_cycles", 8'(nb), 8'd13);
    chk("done_pulses", 8'(nd), 8'd1);
  endtask
  initial begin
    int nd;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_tag", en_sav_swr, 8'h00);
    chk("rst_data", dataWr, 8'h00);
    chk("rst_hour", hour_bcd, 8'h00);
    chk("rst_min", min_bcd, 8'h00);
    chk("rst_seg", seg_bcd, 8'h00);
    chk("rst_sel", {6'b0, field_sel}, 8'd0);
    chk("rst_busy_done", {6'b0, busy, done}, 8'd0);
    press(B_U);
    chk("idle_up_ignored", hour_bcd, 8'h00);
    en = 1'b1;
    tick();
    chk("state_edit", 8'(dut.r_state), 8'(ST_EDIT));
    press(B_U);
    chk("hour_up", hour_bcd, 8'h01);
    press(B_D);
    press(B_D);
    chk("hour_dn_wrap", hour_bcd, 8'h23);
    press(B_U);
    chk("hour_up_wrap", hour_bcd, 8'h00);
    repeat (9) press(B_U);
    chk("hour_09", hour_bcd, 8'h09);
    press(B_U);
    chk("hour_09_up", hour_bcd, 8'h10);
    press(B_D);
    chk("hour_10_dn", hour_bcd, 8'h09);
    repeat (11) press(B_U);
    chk("hour_20", hour_bcd, 8'h20);
    press(B_D);
    chk("hour_20_dn", hour_bcd, 8'h19);
    press(B_R);
    chk("sel_r1", {6'b0, field_sel}, 8'd1);
    press(B_R);
    press(B_R);
    chk("sel_r_wrap", {6'b0, field_sel}, 8'd0);
    press(B_L);
    chk("sel_l_wrap", {6'b0, field_sel}, 8'd2);
    press(B_D);
    chk("seg_dn_wrap", seg_bcd, 8'h59);
    press(B_U);
    chk("seg_up_wrap", seg_bcd, 8'h00);
    repeat (4) press(B_D);
    press(B_L);
    repeat (34) press(B_U);
    press(B_L);
    repeat (7) press(B_D);
    chk("set_hour", hour_bcd, 8'h12);
    chk("set_min", min_bcd, 8'h34);
    chk("set_seg", seg_bcd, 8'h56);
    press(B_U | B_D);
    chk("updown_ignored", hour_bcd, 8'h12);
    press(B_R | B_U);
    chk("right_up_sel", {6'b0, field_sel}, 8'd1);
    chk("right_up_hour", hour_bcd, 8'h12);
    chk("right_up_min", min_bcd, 8'h34);
    btn_up = 1'b1;
    repeat (10) tick();
    btn_up = 1'b0;
    tick();
    chk("held_single", min_bcd, 8'h35);
    press(B_D);
    chk("min_restore", min_bcd, 8'h34);
    burst(1'b0);
    chk("after_burst_edit", 8'(dut.r_state), 8'(ST_EDIT));
    burst(1'b1);
    chk("mess_hour", hour_bcd, 8'h12);
    chk("mess_min", min_bcd, 8'h34);
    chk("mess_seg", seg_bcd, 8'h56);
    chk("mess_idle", 8'(dut.r_state), 8'(ST_IDLE));
    en = 1'b1;
    tick();
    btn_save = 1'b1;
    tick();
    btn_save = 1'b0;
    repeat (5) tick();
    chk("wrm_2nd_tag", en_sav_swr, 8'h42);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en = 1'b0;
    chk("rst_mid_tag", en_sav_swr, 8'h00);
    chk("rst_mid_hour", hour_bcd, 8'h00);
    chk("rst_mid_min", min_bcd, 8'h00);
    chk("rst_mid_seg", seg_bcd, 8'h00);
    chk("rst_mid_busy", {7'b0, busy}, 8'd0);
    nd = int'(done);
    repeat (20) begin
      tick();
      nd += int'(done);
    end
    chk("rst_mid_no_done", 8'(nd), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
